// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares a single memory port among NUM_CH requesters (ifmap decompressor,
// weight buffer, compressor, psum spill, ...). Each channel is either a read
// or a write channel (CH_IS_WR). Grants are round-robin and combinational.
// Each channel owns an auto-incrementing address counter. Reads are tracked
// in a FIFO of channel IDs so that in-order memory returns can be steered back
// to the requester with zero latency.
//
// Optional feature macro: ARB_URGENT_EN
//   When defined, adds input ch_urgent. Eligible urgent channels win over
//   non-urgent ones, lowest index first, and the round-robin pointer is not
//   advanced by urgent grants.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   cfg_start        pulse: load base addresses, flush tracker, clear error
//   cfg_base_addr    per-channel start address (sampled on cfg_start)
//   ch_req           level request per channel
//   ch_wdata         per-channel write data (write channels only)
//   ch_urgent        per-channel urgent flag (ARB_URGENT_EN only)
//   ch_ack           one-hot grant, request accepted this cycle
//   ch_rdata         read data broadcast to all channels
//   ch_rvalid        one-hot: ch_rdata belongs to channel i
//   mem_ready        memory can accept a request this cycle
//   mem_req_valid    request present on mem_* this cycle
//   mem_we           1 = write request
//   mem_addr         request address
//   mem_wdata        write data (0 for reads)
//   mem_rdata        read return data
//   mem_rvalid       read return valid, returns arrive in request order
//   outst_cnt        number of reads in flight
//   err_sticky       a return arrived with nothing in flight
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int                NUM_CH    = 4,
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 256,
  parameter int                MAX_OUTST = 16,
  parameter logic [NUM_CH-1:0] CH_IS_WR  = 4'b0100
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cfg_start,
  input  logic [NUM_CH*ADDR_W-1:0]    cfg_base_addr,
  input  logic [NUM_CH-1:0]           ch_req,
  input  logic [NUM_CH*DATA_W-1:0]    ch_wdata,
`ifdef ARB_URGENT_EN
  input  logic [NUM_CH-1:0]           ch_urgent,
`endif
  output logic [NUM_CH-1:0]           ch_ack,
  output logic [DATA_W-1:0]           ch_rdata,
  output logic [NUM_CH-1:0]           ch_rvalid,
  input  logic                        mem_ready,
  output logic                        mem_req_valid,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  input  logic                        mem_rvalid,
  output logic [$clog2(MAX_OUTST):0]  outst_cnt,
  output logic                        err_sticky
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int PTR_W = $clog2(MAX_OUTST);
  localparam int CNT_W = PTR_W + 1;

  // Per-channel views of the flattened buses and the address counters
  logic [ADDR_W-1:0] addr_arr  [NUM_CH];
  logic [ADDR_W-1:0] base_arr  [NUM_CH];
  logic [DATA_W-1:0] wdata_arr [NUM_CH];

  logic [CH_W-1:0]   rr_ptr_reg;

  // Read tracker: FIFO of channel IDs
  logic [CH_W-1:0]   trk_mem [MAX_OUTST];
  logic [PTR_W-1:0]  trk_rd_reg;
  logic [PTR_W-1:0]  trk_wr_reg;
  logic [CNT_W-1:0]  trk_cnt_reg;
  logic              trk_full;
  logic              trk_empty;
  logic              push;
  logic              pop;
  logic [CH_W-1:0]   trk_head;

  logic              err_reg;

  logic [NUM_CH-1:0] elig;
  logic              rr_valid;
  logic [CH_W-1:0]   rr_idx;
  logic [CH_W:0]     cand;
  logic              grant_valid;
  logic [CH_W-1:0]   grant_idx;
  logic              ptr_adv;

  assign trk_full  = (trk_cnt_reg == CNT_W'(MAX_OUTST));
  assign trk_empty = (trk_cnt_reg == '0);

  // ---------------------------------------------------------------------------
  // Per-channel eligibility and address counters
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [ADDR_W-1:0] addr_reg;

    assign base_arr[gi]  = cfg_base_addr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = ch_wdata[gi*DATA_W +: DATA_W];
    assign addr_arr[gi]  = addr_reg;

    // Fullness is judged on the registered count, so a pop in the same
    // cycle does not open a slot for a new read.
    assign elig[gi] = ch_req[gi] & mem_ready & ~cfg_start & rst_n &
                      (CH_IS_WR[gi] | ~trk_full);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        addr_reg <= '0;
      end else if (cfg_start) begin
        addr_reg <= base_arr[gi];
      end else if (grant_valid && (grant_idx == CH_W'(gi))) begin
        addr_reg <= addr_reg + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin search from rr_ptr_reg. Scanning from the far end down means
  // the last hit written is the nearest eligible channel to the pointer.
  // ---------------------------------------------------------------------------
  always_comb begin
    rr_valid = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_reg} + (CH_W+1)'(k);
      if (cand >= (CH_W+1)'(NUM_CH)) begin
        cand = cand - (CH_W+1)'(NUM_CH);
      end
      if (elig[cand[CH_W-1:0]]) begin
        rr_valid = 1'b1;
        rr_idx   = cand[CH_W-1:0];
      end
    end
  end

`ifdef ARB_URGENT_EN
  logic            urg_valid;
  logic [CH_W-1:0] urg_idx;

  // Lowest-index eligible urgent channel
  always_comb begin
    urg_valid = 1'b0;
    urg_idx   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (elig[k] && ch_urgent[k]) begin
        urg_valid = 1'b1;
        urg_idx   = CH_W'(k);
      end
    end
  end

  assign grant_valid = urg_valid | rr_valid;
  assign grant_idx   = urg_valid ? urg_idx : rr_idx;
  assign ptr_adv     = rr_valid & ~urg_valid;
`else
  assign grant_valid = rr_valid;
  assign grant_idx   = rr_idx;
  assign ptr_adv     = rr_valid;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg <= '0;
    end else if (cfg_start) begin
      rr_ptr_reg <= '0;
    end else if (ptr_adv) begin
      rr_ptr_reg <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory request and grant outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    ch_ack        = '0;
    mem_req_valid = grant_valid;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    if (grant_valid) begin
      ch_ack[grant_idx] = 1'b1;
      mem_we            = CH_IS_WR[grant_idx];
      mem_addr          = addr_arr[grant_idx];
      if (CH_IS_WR[grant_idx]) begin
        mem_wdata = wdata_arr[grant_idx];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read tracker. Small enough for LUT storage; the head is read
  // combinationally so returns are steered in the same cycle.
  // ---------------------------------------------------------------------------
  assign push     = grant_valid & ~CH_IS_WR[grant_idx];
  assign pop      = mem_rvalid & ~trk_empty;
  assign trk_head = trk_mem[trk_rd_reg];

  always_ff @(posedge clk) begin
    if (push) begin
      trk_mem[trk_wr_reg] <= grant_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trk_rd_reg  <= '0;
      trk_wr_reg  <= '0;
      trk_cnt_reg <= '0;
    end else if (cfg_start) begin
      trk_rd_reg  <= '0;
      trk_wr_reg  <= '0;
      trk_cnt_reg <= '0;
    end else begin
      if (push) begin
        trk_wr_reg <= trk_wr_reg + 1'b1;
      end
      if (pop) begin
        trk_rd_reg <= trk_rd_reg + 1'b1;
      end
      trk_cnt_reg <= trk_cnt_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // A return with nothing in flight is dropped and flagged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else if (cfg_start) begin
      err_reg <= 1'b0;
    end else if (mem_rvalid && trk_empty) begin
      err_reg <= 1'b1;
    end
  end

  always_comb begin
    ch_rvalid = '0;
    if (pop) begin
      ch_rvalid[trk_head] = 1'b1;
    end
  end

  assign ch_rdata   = mem_rdata;
  assign outst_cnt  = trk_cnt_reg;
  assign err_sticky = err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Scoreboard bench for mem_port_arbiter. The stimulus task computes, from a
// queue/array level model of the arbiter rules, the grants, responses and
// tracker status each cycle should produce and pushes them into queues; a
// negedge monitor pops and compares whenever the DUT presents them.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
  localparam int NUM_CH    = 4;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 256;
  localparam int MAX_OUTST = 16;
  localparam logic [NUM_CH-1:0] CH_IS_WR = 4'b0100;

  logic                       clk;
  logic                       rst_n;
  logic                       cfg_start;
  logic [NUM_CH*ADDR_W-1:0]   cfg_base_addr;
  logic [NUM_CH-1:0]          ch_req;
  logic [NUM_CH*DATA_W-1:0]   ch_wdata;
  logic [NUM_CH-1:0]          ch_ack;
  logic [DATA_W-1:0]          ch_rdata;
  logic [NUM_CH-1:0]          ch_rvalid;
  logic                       mem_ready;
  logic                       mem_req_valid;
  logic                       mem_we;
  logic [ADDR_W-1:0]          mem_addr;
  logic [DATA_W-1:0]          mem_wdata;
  logic [DATA_W-1:0]          mem_rdata;
  logic                       mem_rvalid;
  logic [$clog2(MAX_OUTST):0] outst_cnt;
  logic                       err_sticky;
`ifdef ARB_URGENT_EN
  logic [NUM_CH-1:0]          ch_urgent;
  assign ch_urgent = '0;
`endif

  mem_port_arbiter #(
    .NUM_CH   (NUM_CH),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_OUTST(MAX_OUTST),
    .CH_IS_WR (CH_IS_WR)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_start    (cfg_start),
    .cfg_base_addr(cfg_base_addr),
    .ch_req       (ch_req),
    .ch_wdata     (ch_wdata),
`ifdef ARB_URGENT_EN
    .ch_urgent    (ch_urgent),
`endif
    .ch_ack       (ch_ack),
    .ch_rdata     (ch_rdata),
    .ch_rvalid    (ch_rvalid),
    .mem_ready    (mem_ready),
    .mem_req_valid(mem_req_valid),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_rvalid   (mem_rvalid),
    .outst_cnt    (outst_cnt),
    .err_sticky   (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int                ch;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] wdata;
  } grant_t;

  typedef struct {
    int                ch;
    logic [DATA_W-1:0] data;
  } resp_t;

  typedef struct {
    int   cnt;
    logic err;
  } stat_t;

  grant_t grant_q[$];
  resp_t  resp_q[$];
  stat_t  stat_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [ADDR_W-1:0] m_addr   [NUM_CH];
  logic [ADDR_W-1:0] base_tbl [NUM_CH];
  int                m_ptr;
  int                m_outst[$];
  logic              m_err;

  task automatic chk(input string name, input logic ok,
                     input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand256();
    logic [DATA_W-1:0] v;
    for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // One clock of stimulus plus the model's expectations for that cycle
  task automatic cycle(input logic rst_i, input logic cfg_i, input logic ready_i,
                       input logic rv_i, input logic [NUM_CH-1:0] req_i);
    int     n_before;
    int     g;
    grant_t ge;
    resp_t  re;
    stat_t  se;
    @(posedge clk);
    #1;
    rst_n      = rst_i;
    cfg_start  = cfg_i;
    mem_ready  = ready_i;
    mem_rvalid = rv_i;
    ch_req     = req_i;
    mem_rdata  = rand256();
    for (int i = 0; i < NUM_CH; i++) begin
      ch_wdata[i*DATA_W +: DATA_W]      = rand256();
      cfg_base_addr[i*ADDR_W +: ADDR_W] = base_tbl[i];
    end
    if (!rst_i) begin
      m_ptr = 0;
      for (int i = 0; i < NUM_CH; i++) m_addr[i] = '0;
      m_outst.delete();
      m_err = 1'b0;
    end
    n_before = m_outst.size();
    se.cnt = n_before;
    se.err = m_err;
    stat_q.push_back(se);
    if (rst_i) begin
      g = -1;
      if (ready_i && !cfg_i) begin
        for (int k = 0; k < NUM_CH; k++) begin
          int c;
          c = (m_ptr + k) % NUM_CH;
          if (g < 0 && req_i[c] && (CH_IS_WR[c] || n_before < MAX_OUTST)) g = c;
        end
      end
      if (g >= 0) begin
        ge.ch    = g;
        ge.addr  = m_addr[g];
        ge.we    = CH_IS_WR[g];
        ge.wdata = CH_IS_WR[g] ? ch_wdata[g*DATA_W +: DATA_W] : '0;
        grant_q.push_back(ge);
        m_addr[g] = m_addr[g] + 1;
        m_ptr     = (g + 1) % NUM_CH;
      end
      if (rv_i) begin
        if (n_before > 0) begin
          re.ch   = m_outst.pop_front();
          re.data = mem_rdata;
          resp_q.push_back(re);
        end else begin
          m_err = 1'b1;
        end
      end
      if (g >= 0 && !CH_IS_WR[g]) m_outst.push_back(g);
      if (cfg_i) begin
        for (int i = 0; i < NUM_CH; i++) m_addr[i] = base_tbl[i];
        m_outst.delete();
        m_ptr = 0;
        m_err = 1'b0;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * MAX_OUTST && m_outst.size() > 0; i++) cycle(1, 0, 1, 1, '0);
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations
  always @(negedge clk) begin
    stat_t  s;
    grant_t g;
    resp_t  r;
    if (stat_q.size() > 0) begin
      s = stat_q.pop_front();
      chk("outst_cnt", outst_cnt == 5'(s.cnt), DATA_W'(outst_cnt), DATA_W'(s.cnt));
      chk("err_sticky", err_sticky == s.err, DATA_W'(err_sticky), DATA_W'(s.err));
    end
    if (mem_req_valid || ch_ack != '0) begin
      if (grant_q.size() == 0) begin
        chk("unexpected_grant", 1'b0, DATA_W'(ch_ack), '0);
      end else begin
        g = grant_q.pop_front();
        $display("grant ch=%0d addr=%h we=%0b", g.ch, mem_addr, mem_we);
        chk("ch_ack", ch_ack == (4'b0001 << g.ch), DATA_W'(ch_ack), DATA_W'(4'b0001 << g.ch));
        chk("mem_req_valid", mem_req_valid == 1'b1, DATA_W'(mem_req_valid), DATA_W'(1));
        chk("mem_addr", mem_addr == g.addr, DATA_W'(mem_addr), DATA_W'(g.addr));
        chk("mem_we", mem_we == g.we, DATA_W'(mem_we), DATA_W'(g.we));
        chk("mem_wdata", mem_wdata == g.wdata, mem_wdata, g.wdata);
      end
    end else begin
      chk("idle_addr", mem_addr == '0, DATA_W'(mem_addr), '0);
      chk("idle_wdata", mem_wdata == '0, mem_wdata, '0);
    end
    if (ch_rvalid != '0) begin
      if (resp_q.size() == 0) begin
        chk("unexpected_rvalid", 1'b0, DATA_W'(ch_rvalid), '0);
      end else begin
        r = resp_q.pop_front();
        $display("resp  ch=%0d", r.ch);
        chk("ch_rvalid", ch_rvalid == (4'b0001 << r.ch), DATA_W'(ch_rvalid), DATA_W'(4'b0001 << r.ch));
        chk("ch_rdata", ch_rdata == r.data, ch_rdata, r.data);
      end
    end
  end

  initial begin
    logic cfg_r;
    logic rst_r;
    rst_n         = 1'b0;
    cfg_start     = 1'b0;
    cfg_base_addr = '0;
    ch_req        = '0;
    ch_wdata      = '0;
    mem_ready     = 1'b0;
    mem_rdata     = '0;
    mem_rvalid    = 1'b0;
    base_tbl[0] = 32'h100;
    base_tbl[1] = 32'h200;
    base_tbl[2] = 32'h300;
    base_tbl[3] = 32'h400;

    // Reset, then load bases with every channel requesting (no grant that cycle)
    cycle(0, 0, 0, 0, 4'h0);
    cycle(0, 0, 1, 0, 4'hF);
    cycle(1, 0, 0, 0, 4'h0);
    cycle(1, 1, 1, 0, 4'hF);

    // Full round-robin rotation, ch2 writes
    repeat (8) cycle(1, 0, 1, 0, 4'hF);
    drain();

    // Ch0 three reads, three returns
    repeat (3) cycle(1, 0, 1, 0, 4'h1);
    repeat (3) cycle(1, 0, 1, 1, 4'h0);

    // Ch0/ch1 interleaved reads, in-order returns
    repeat (4) cycle(1, 0, 1, 0, 4'h3);
    repeat (4) cycle(1, 0, 1, 1, 4'h0);

    // Fill the tracker, then ch1 must wait until a pop has been registered
    repeat (MAX_OUTST) cycle(1, 0, 1, 0, 4'h1);
    repeat (2) cycle(1, 0, 1, 0, 4'h2);
    cycle(1, 0, 1, 1, 4'h2);
    cycle(1, 0, 1, 0, 4'h2);
    drain();

    // Back-pressure: pointer must hold while mem_ready is low
    cycle(1, 0, 1, 0, 4'h2);
    repeat (5) cycle(1, 0, 0, 0, 4'hF);
    cycle(1, 0, 1, 0, 4'hF);
    drain();

    // Unexpected return, clear via cfg_start, address wrap
    cycle(1, 0, 1, 1, 4'h0);
    cycle(1, 0, 1, 0, 4'h0);
    base_tbl[0] = 32'hFFFF_FFFF;
    cycle(1, 1, 1, 0, 4'h0);
    repeat (2) cycle(1, 0, 1, 0, 4'h1);
    drain();

    // Reset mid-operation: later returns are unexpected
    repeat (3) cycle(1, 0, 1, 0, 4'h3);
    cycle(0, 0, 1, 0, 4'h0);
    cycle(1, 0, 1, 0, 4'h0);
    cycle(1, 0, 1, 1, 4'h0);
    cycle(1, 0, 1, 0, 4'h0);
    cycle(1, 1, 1, 0, 4'h0);

    // Randomized traffic
    repeat (3000) begin
      cfg_r = ($urandom_range(0, 99) == 0);
      rst_r = ($urandom_range(0, 499) != 0);
      if (cfg_r) begin
        for (int i = 0; i < NUM_CH; i++)
          base_tbl[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : 32'($urandom());
      end
      cycle(rst_r, cfg_r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 6),
            4'($urandom()));
    end
    drain();
    cycle(1, 0, 1, 0, 4'h0);
    @(negedge clk);
    #1;
    chk("grant_q_empty", grant_q.size() == 0, DATA_W'(grant_q.size()), '0);
    chk("resp_q_empty", resp_q.size() == 0, DATA_W'(resp_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
